// File: rtl/clock_set_controller.sv
// rtl/clock_set_controller.sv - UART command parser and adjust-strobe sequencer for the clock_calendar core
module clock_set_controller #(
    parameter int TIMEOUT_CYCLES = 50_000_000,
    parameter int CNT_W          = 26
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    input  logic       btn_hour,
    input  logic       btn_min,
    output logic       load_time,
    output logic [7:0] load_hour,
    output logic [7:0] load_min,
    output logic [7:0] load_sec,
    output logic       inc_hour,
    output logic       inc_min,
    output logic       pause,
    output logic       fast,
    output logic       cmd_error,
    output logic       busy
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DIG   = 2'd1,
        S_CHECK = 2'd2
    } state_t;

    // Timeout fires on the cycle the counter would reach TIMEOUT_CYCLES.
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t           state_q, state_n;
    logic [2:0]       idx_q, idx_n;
    logic [CNT_W-1:0] cnt_q, cnt_n;
    logic [23:0]      dig_q, dig_n;      // H1 in [23:20] down to S0 in [3:0]
    logic             pause_n, fast_n;
    logic             load_n, err_n;
    logic             btn_hour_q, btn_min_q;
    logic             pend_hour_q, pend_min_q;
    logic             want_hour, want_min;
    logic             is_digit;
    logic             fields_ok;
    logic [4:0]       dig_lsb;

    assign is_digit  = (rx_data >= 8'h30) && (rx_data <= 8'h39);
    assign dig_lsb   = 5'd20 - {idx_q, 2'b00};
    // Digits are 0-9 per nibble, so a plain compare of the packed BCD hour works.
    assign fields_ok = (dig_q[23:16] <= 8'h23) && (dig_q[15:12] <= 4'd5) && (dig_q[7:4] <= 4'd5);
    assign busy      = (state_q != S_IDLE);

    // A pending inc merges with any new edge of the same button into one strobe.
    assign want_hour = (btn_hour & ~btn_hour_q) | pend_hour_q;
    assign want_min  = (btn_min & ~btn_min_q) | pend_min_q;

    // Frame parser: next state, digit capture, timeout and command toggles.
    always_comb begin
        state_n = state_q;
        idx_n   = idx_q;
        cnt_n   = cnt_q;
        dig_n   = dig_q;
        pause_n = pause;
        fast_n  = fast;
        load_n  = 1'b0;
        err_n   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (rx_valid) begin
                    case (rx_data)
                        8'h54: begin
                            state_n = S_DIG;
                            idx_n   = 3'd0;
                            cnt_n   = '0;
                        end
                        8'h50:   pause_n = ~pause;
                        8'h46:   fast_n  = ~fast;
                        default: ;
                    endcase
                end
            end
            S_DIG: begin
                if (rx_valid) begin
                    if (is_digit) begin
                        dig_n[dig_lsb +: 4] = rx_data[3:0];
                        idx_n = idx_q + 3'd1;
                        cnt_n = '0;
                        if (idx_q == 3'd5) begin
                            state_n = S_CHECK;
                        end
                    end else begin
                        state_n = S_IDLE;
                        err_n   = 1'b1;
                    end
                end else if (cnt_q == TO_LAST) begin
                    state_n = S_IDLE;
                    err_n   = 1'b1;
                end else begin
                    cnt_n = cnt_q + 1'b1;
                end
            end
            S_CHECK: begin
                state_n = S_IDLE;
                if (fields_ok) begin
                    load_n = 1'b1;
                end else begin
                    err_n = 1'b1;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    // Parser state, level outputs and registered load/error strobes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            idx_q     <= '0;
            cnt_q     <= '0;
            dig_q     <= '0;
            pause     <= 1'b0;
            fast      <= 1'b0;
            load_time <= 1'b0;
            cmd_error <= 1'b0;
            load_hour <= '0;
            load_min  <= '0;
            load_sec  <= '0;
        end else begin
            state_q   <= state_n;
            idx_q     <= idx_n;
            cnt_q     <= cnt_n;
            dig_q     <= dig_n;
            pause     <= pause_n;
            fast      <= fast_n;
            load_time <= load_n;
            cmd_error <= err_n;
            if (load_n) begin
                load_hour <= dig_q[23:16];
                load_min  <= dig_q[15:8];
                load_sec  <= dig_q[7:0];
            end
        end
    end

    // Button edge strobes; a load_time cycle defers them by one cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            btn_hour_q  <= 1'b0;
            btn_min_q   <= 1'b0;
            pend_hour_q <= 1'b0;
            pend_min_q  <= 1'b0;
            inc_hour    <= 1'b0;
            inc_min     <= 1'b0;
        end else begin
            btn_hour_q <= btn_hour;
            btn_min_q  <= btn_min;
            if (load_n) begin
                inc_hour    <= 1'b0;
                inc_min     <= 1'b0;
                pend_hour_q <= want_hour;
                pend_min_q  <= want_min;
            end else begin
                inc_hour    <= want_hour;
                inc_min     <= want_min;
                pend_hour_q <= 1'b0;
                pend_min_q  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_clock_set_controller.sv
// tb/tb_clock_set_controller.sv - randomized self-checking bench for clock_set_controller
module tb_clock_set_controller;

    localparam int TO = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       btn_hour;
    logic       btn_min;
    logic       load_time;
    logic [7:0] load_hour;
    logic [7:0] load_min;
    logic [7:0] load_sec;
    logic       inc_hour;
    logic       inc_min;
    logic       pause;
    logic       fast;
    logic       cmd_error;
    logic       busy;

    always #5 clk = ~clk;

    clock_set_controller #(
        .TIMEOUT_CYCLES(TO),
        .CNT_W         (8)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .btn_hour (btn_hour),
        .btn_min  (btn_min),
        .load_time(load_time),
        .load_hour(load_hour),
        .load_min (load_min),
        .load_sec (load_sec),
        .inc_hour (inc_hour),
        .inc_min  (inc_min),
        .pause    (pause),
        .fast     (fast),
        .cmd_error(cmd_error),
        .busy     (busy)
    );

    int n_pass = 0;
    int n_chk  = 0;
    int cyc    = 0;

    // Reference model: frame progress plus events scheduled by absolute cycle.
    int          mode;            // 0 no frame, 1 collecting digits, 2 frame complete
    int          last_byte;
    int          digs[$];
    bit          m_pause, m_fast, m_busy;
    bit          prev_h, prev_m;
    bit          ev_load[int];
    logic [23:0] ev_val[int];
    bit          ev_err[int];
    bit          ev_inch[int];
    bit          ev_incm[int];
    logic [23:0] cur_load;
    bit          bh_lvl, bm_lvl, rand_btn;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
    endtask

    function automatic int inc_slot(input int c);
        int t = c + 1;
        if (ev_load.exists(t)) t++;
        return t;
    endfunction

    function automatic bit time_ok();
        int hh = digs[0] * 10 + digs[1];
        int mm = digs[2] * 10 + digs[3];
        int ss = digs[4] * 10 + digs[5];
        return (hh <= 23) && (mm <= 59) && (ss <= 59);
    endfunction

    task automatic model_reset();
        mode = 0; last_byte = 0; digs.delete();
        m_pause = 0; m_fast = 0; m_busy = 0; prev_h = 0; prev_m = 0;
        ev_load.delete(); ev_val.delete(); ev_err.delete();
        ev_inch.delete(); ev_incm.delete(); cur_load = '0;
    endtask

    task automatic model_step(input bit v, input logic [7:0] d, input bit bh, input bit bm);
        if (bh && !prev_h) ev_inch[inc_slot(cyc)] = 1'b1;
        if (bm && !prev_m) ev_incm[inc_slot(cyc)] = 1'b1;
        prev_h = bh;
        prev_m = bm;
        case (mode)
            0: if (v) begin
                if (d == 8'h54) begin mode = 1; digs.delete(); last_byte = cyc; end
                else if (d == 8'h50) m_pause = !m_pause;
                else if (d == 8'h46) m_fast = !m_fast;
            end
            1: if (v) begin
                if (d >= 8'h30 && d <= 8'h39) begin
                    digs.push_back(int'(d) - 48);
                    last_byte = cyc;
                    if (digs.size() == 6) begin
                        if (time_ok()) begin
                            ev_load[cyc + 2] = 1'b1;
                            ev_val[cyc + 2]  = {digs[0][3:0], digs[1][3:0], digs[2][3:0],
                                                digs[3][3:0], digs[4][3:0], digs[5][3:0]};
                        end else begin
                            ev_err[cyc + 2] = 1'b1;
                        end
                        mode = 2;
                    end
                end else begin
                    ev_err[cyc + 1] = 1'b1;
                    mode = 0;
                end
            end else if (cyc - last_byte == TO) begin
                ev_err[cyc + 1] = 1'b1;
                mode = 0;
            end
            default: mode = 0;
        endcase
        m_busy = (mode != 0);
    endtask

    task automatic check_outputs();
        bit el = ev_load.exists(cyc);
        if (el) cur_load = ev_val[cyc];
        check("load_time", load_time, el);
        check("cmd_error", cmd_error, ev_err.exists(cyc));
        check("inc_hour",  inc_hour,  ev_inch.exists(cyc));
        check("inc_min",   inc_min,   ev_incm.exists(cyc));
        check("load_hour", load_hour, cur_load[23:16]);
        check("load_min",  load_min,  cur_load[15:8]);
        check("load_sec",  load_sec,  cur_load[7:0]);
        check("pause",     pause,     m_pause);
        check("fast",      fast,      m_fast);
        check("busy",      busy,      m_busy);
    endtask

    task automatic tick(input bit v, input logic [7:0] d);
        check_outputs();
        if (rand_btn) begin
            if ($urandom_range(0, 5) == 0) bh_lvl = !bh_lvl;
            if ($urandom_range(0, 5) == 0) bm_lvl = !bm_lvl;
        end
        rx_valid = v;
        rx_data  = d;
        btn_hour = bh_lvl;
        btn_min  = bm_lvl;
        model_step(v, d, bh_lvl, bm_lvl);
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic send(input logic [7:0] b);
        tick(1'b1, b);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 8'h00);
    endtask

    task automatic send_frame(input string s);
        for (int i = 0; i < s.len(); i++) send(s[i]);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_outs"}, {load_time, load_hour, load_min, load_sec, inc_hour,
                               inc_min, pause, fast, cmd_error, busy}, 32'd0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        rx_valid = 1'b0; rx_data = 8'h00;
        bh_lvl = 0; bm_lvl = 0; btn_hour = 0; btn_min = 0;
        #2;
        check_all_zero("reset");
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        cyc++;
    endtask

    initial begin
        rst = 1'b1; rx_valid = 0; rx_data = 0; btn_hour = 0; btn_min = 0;
        bh_lvl = 0; bm_lvl = 0; rand_btn = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("por");
        rst = 1'b0;

        // Directed scenarios
        send_frame("T123456"); idle(4);
        send_frame("T240000"); idle(4);
        send_frame("T235959"); idle(4);
        send_frame("T12X");    send(8'h50); idle(3);
        send_frame("T1");      idle(TO + 4);
        send_frame("T010203"); idle(4);
        send_frame("T12345");  send(8'h36);
        bh_lvl = 1;            idle(5);
        bh_lvl = 0;            idle(2);
        bh_lvl = 1; bm_lvl = 1; idle(3);
        bh_lvl = 0; bm_lvl = 0; idle(2);
        send_frame("T123");
        do_reset();
        send(8'h46); idle(3);
        send_frame("T1T"); send(8'h50); send(8'h70); idle(3);

        // Randomized traffic with free-running button activity
        rand_btn = 1;
        for (int it = 0; it < 300; it++) begin
            int kind = $urandom_range(0, 9);
            if (kind < 6) begin
                logic [7:0] fr[7];
                int nb;
                fr[0] = 8'h54;
                fr[1] = 8'h30 + 8'($urandom_range(0, 2));
                fr[2] = 8'h30 + 8'($urandom_range(0, 9));
                fr[3] = 8'h30 + 8'($urandom_range(0, 6));
                fr[4] = 8'h30 + 8'($urandom_range(0, 9));
                fr[5] = 8'h30 + 8'($urandom_range(0, 6));
                fr[6] = 8'h30 + 8'($urandom_range(0, 9));
                nb = ($urandom_range(0, 9) == 0) ? int'($urandom_range(2, 6)) : 7;
                if (nb < 7) fr[nb] = 8'($urandom_range(0, 255));
                for (int k = 0; k < nb + 1 && k < 7; k++) begin
                    send(fr[k]);
                    if ($urandom_range(0, 19) == 0) idle($urandom_range(TO - 2, TO + 2));
                    else idle($urandom_range(0, 2));
                end
            end else if (kind == 6) begin
                send($urandom_range(0, 1) ? 8'h50 : 8'h46);
            end else if (kind == 7) begin
                send(8'($urandom_range(0, 255)));
            end else if (kind == 8) begin
                idle($urandom_range(1, TO + 3));
            end else begin
                if ($urandom_range(0, 3) == 0) do_reset();
                else idle($urandom_range(0, 4));
            end
        end
        rand_btn = 0;
        idle(TO + 4);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
